// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory: power-up fill with INIT_VALUE, then one-cycle
// registered fetch with address-fault flagging and an independent program-load port.
module instr_mem_sync #(
  parameter int          DEPTH      = 128,
  parameter int          IDX_W      = 7,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Address,
  input  logic        ReadEn,
  input  logic        Stall,
  input  logic        WriteEn,
  input  logic [31:0] WriteAddress,
  input  logic [31:0] WriteData,
  output logic [31:0] Instruction,
  output logic        Valid,
  output logic        Busy,
  output logic        AddrFault
);

  typedef enum logic {FILL, RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  fill_cnt;
  logic [31:0]       mem [DEPTH];

  logic [IDX_W-1:0]  rd_idx_p0;
  logic [IDX_W-1:0]  wr_idx_p0;
  logic              rd_ok_p0;
  logic              wr_ok_p0;
  logic              mem_we_p0;
  logic [IDX_W-1:0]  mem_wa_p0;
  logic [31:0]       mem_wd_p0;

  logic [31:0]       instr_p1;
  logic              vld_p1;
  logic              fault_p1;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> (IDX_W + 2)) == 32'd0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return a[IDX_W+1:2];
  endfunction

  // Stage p0: address decode and write-port arbitration (fill owns the port while busy)
  always_comb begin
    rd_idx_p0 = word_idx(Address);
    wr_idx_p0 = word_idx(WriteAddress);
    rd_ok_p0  = addr_legal(Address);
    wr_ok_p0  = addr_legal(WriteAddress);
    mem_we_p0 = 1'b0;
    mem_wa_p0 = wr_idx_p0;
    mem_wd_p0 = WriteData;
    if (!Rst) begin
      if (state == FILL) begin
        mem_we_p0 = 1'b1;
        mem_wa_p0 = fill_cnt;
        mem_wd_p0 = INIT_VALUE;
      end else if (WriteEn && wr_ok_p0) begin
        mem_we_p0 = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we_p0) mem[mem_wa_p0] <= mem_wd_p0;
  end

  // Stage p1: registered fetch result; the array read sees pre-write contents
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= FILL;
      fill_cnt <= '0;
      instr_p1 <= 32'h0000_0000;
      vld_p1   <= 1'b0;
      fault_p1 <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == IDX_W'(DEPTH - 1)) state <= RUN;
          vld_p1   <= 1'b0;
          fault_p1 <= 1'b0;
        end
        RUN: begin
          if (!Stall) begin
            if (ReadEn) begin
              vld_p1 <= 1'b1;
              if (rd_ok_p0) begin
                instr_p1 <= mem[rd_idx_p0];
                fault_p1 <= 1'b0;
              end else begin
                instr_p1 <= INIT_VALUE;
                fault_p1 <= 1'b1;
              end
            end else begin
              vld_p1   <= 1'b0;
              fault_p1 <= 1'b0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign Instruction = instr_p1;
  assign Valid       = vld_p1;
  assign AddrFault   = fault_p1;
  assign Busy        = (state == FILL);

endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync: the driver queues hand-computed fetch results,
// the monitor tracks fill/hold behaviour per edge and compares every output.
module tb_instr_mem_sync;
  localparam int DEPTH = 128;
  localparam int IDX_W = 7;

  logic        Clk;
  logic        Rst;
  logic [31:0] Address;
  logic        ReadEn;
  logic        Stall;
  logic        WriteEn;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic [31:0] Instruction;
  logic        Valid;
  logic        Busy;
  logic        AddrFault;

  instr_mem_sync #(.DEPTH(DEPTH), .IDX_W(IDX_W), .INIT_VALUE(32'h0000_0000)) dut (
    .Clk(Clk), .Rst(Rst), .Address(Address), .ReadEn(ReadEn), .Stall(Stall),
    .WriteEn(WriteEn), .WriteAddress(WriteAddress), .WriteData(WriteData),
    .Instruction(Instruction), .Valid(Valid), .Busy(Busy), .AddrFault(AddrFault)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: reference model of busy/valid/instruction, fed by the expected queue
  logic        s_rst, s_rd, s_stall;
  logic        busy_m;
  int          fill_m;
  logic [31:0] e_ins;
  logic        e_vld, e_flt;
  logic [32:0] popped;

  always @(posedge Clk) begin
    s_rst   = Rst;
    s_rd    = ReadEn;
    s_stall = Stall;
    #1;
    if (s_rst) begin
      busy_m = 1'b1; fill_m = 0;
      e_ins = 32'h0; e_vld = 1'b0; e_flt = 1'b0;
    end else if (busy_m) begin
      fill_m++;
      if (fill_m == DEPTH) busy_m = 1'b0;
      e_vld = 1'b0; e_flt = 1'b0;
    end else if (!s_stall) begin
      if (s_rd) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fetch: no queued expectation at %0t", $time);
          e_vld = 1'b1;
        end else begin
          popped = exp_q.pop_front();
          e_vld = 1'b1; e_flt = popped[32]; e_ins = popped[31:0];
        end
      end else begin
        e_vld = 1'b0; e_flt = 1'b0;
      end
    end
    chk("busy", 32'(Busy), 32'(busy_m));
    chk("valid", 32'(Valid), 32'(e_vld));
    chk("addrfault", 32'(AddrFault), 32'(e_flt));
    chk("instruction", Instruction, e_ins);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef);
    Address = a;
    ReadEn  = 1'b1;
    exp_q.push_back({ef, ei});
    @(negedge Clk);
    ReadEn = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    WriteEn = 1'b1; WriteAddress = a; WriteData = d;
    @(negedge Clk);
    WriteEn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b1; Address = 32'h0; ReadEn = 1'b0; Stall = 1'b0;
    WriteEn = 1'b0; WriteAddress = 32'h0; WriteData = 32'h0;
    idle(3);
    Rst = 1'b0;
    idle(DEPTH);

    for (int i = 0; i < DEPTH; i++) fetch(32'(i * 4), 32'h0, 1'b0);
    idle(1);

    wr(32'h4, 32'h2232_0002);
    fetch(32'h4, 32'h2232_0002, 1'b0);

    WriteEn = 1'b1; WriteAddress = 32'h8; WriteData = 32'hDEAD_BEEF;
    fetch(32'h8, 32'h0, 1'b0);
    WriteEn = 1'b0;
    fetch(32'h8, 32'hDEAD_BEEF, 1'b0);

    fetch(32'h6, 32'h0, 1'b1);
    fetch(32'h200, 32'h0, 1'b1);
    wr(32'h200, 32'h1234_5678);
    wr(32'h6, 32'h8765_4321);
    fetch(32'h0, 32'h0, 1'b0);
    fetch(32'h4, 32'h2232_0002, 1'b0);
    fetch(32'h8, 32'hDEAD_BEEF, 1'b0);
    idle(1);

    wr(32'hC, 32'hA5A5_0003);
    fetch(32'hC, 32'hA5A5_0003, 1'b0);
    Stall = 1'b1; ReadEn = 1'b1;
    Address = 32'h4; idle(1);
    Address = 32'h6; idle(1);
    Address = 32'h8;
    wr(32'h10, 32'h0000_0010);
    Stall = 1'b0; ReadEn = 1'b0;
    fetch(32'h10, 32'h0000_0010, 1'b0);
    idle(1);

    wr(32'h14, 32'h1111_2222);
    fetch(32'h14, 32'h1111_2222, 1'b0);
    Rst = 1'b1; ReadEn = 1'b1; Address = 32'h4;
    idle(2);
    Rst = 1'b0;
    WriteEn = 1'b1; WriteAddress = 32'h4; WriteData = 32'hFFFF_FFFF;
    idle(DEPTH);
    ReadEn = 1'b0; WriteEn = 1'b0;
    fetch(32'h4, 32'h0, 1'b0);
    fetch(32'h8, 32'h0, 1'b0);
    fetch(32'hC, 32'h0, 1'b0);
    fetch(32'h14, 32'h0, 1'b0);
    idle(3);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_mem_sync.md
INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 128, meaning the number of 32-bit instruction words (power of two, minimum 4).
REQ-002 The block SHALL have the parameter IDX_W, default 7, meaning the word-index width, equal to log2(DEPTH).
REQ-003 The block SHALL have the parameter INIT_VALUE, default 32'h0000_0000, meaning the fill word and fault word (NOP).
REQ-004 The block SHALL have the port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have the port Address, input, 32 bits: fetch byte address.
REQ-007 The block SHALL have the port ReadEn, input, 1 bit: fetch request.
REQ-008 The block SHALL have the port Stall, input, 1 bit: holds all read outputs.
REQ-009 The block SHALL have the port WriteEn, input, 1 bit: program-load write strobe.
REQ-010 The block SHALL have the port WriteAddress, input, 32 bits: program-load byte address.
REQ-011 The block SHALL have the port WriteData, input, 32 bits: program-load word.
REQ-012 The block SHALL have the port Instruction, output, 32 bits: registered fetched word.
REQ-013 The block SHALL have the port Valid, output, 1 bit: Instruction corresponds to a fetch issued the previous accepted cycle.
REQ-014 The block SHALL have the port Busy, output, 1 bit: fill in progress; reads and writes are ignored.
REQ-015 The block SHALL have the port AddrFault, output, 1 bit: the delivered fetch had a misaligned or out-of-range address.

Function
REQ-016 Word index SHALL be Address[IDX_W+1:2]; an address is legal only if Address[1:0]==0 and Address[31:IDX_W+2]==0 (same rule for WriteAddress).
REQ-017 Controller SHALL be a two-state FSM, FILL and RUN; Rst forces FILL with fill counter 0.
REQ-018 In FILL, each rising edge SHALL write INIT_VALUE to word[counter] and increment the counter; on the edge writing word DEPTH-1, the FSM SHALL go to RUN.
REQ-019 Busy SHALL be 1 in FILL and 0 in RUN; it SHALL fall exactly DEPTH rising edges after the first edge with Rst=0.
REQ-020 In FILL, ReadEn and WriteEn SHALL be ignored, and Valid SHALL be 0.
REQ-021 In RUN with Stall=0 and ReadEn=1, the next edge SHALL load Instruction=word[index], Valid=1, AddrFault=0 (latency 1 cycle).
REQ-022 For an illegal read address, the next edge SHALL instead load Instruction=INIT_VALUE, Valid=1, AddrFault=1; memory SHALL be unaffected.
REQ-023 In RUN with Stall=0 and ReadEn=0, the next edge SHALL set Valid=0 and AddrFault=0; Instruction SHALL hold.
REQ-024 With Stall=1, Instruction, Valid and AddrFault SHALL hold their values; no new fetch is accepted.
REQ-025 In RUN with WriteEn=1 and a legal WriteAddress, word[index] SHALL take WriteData at the edge, independent of Stall; an illegal WriteAddress SHALL write nothing.
REQ-026 A read and a write to the same word in the same cycle SHALL return the old contents (read-before-write); a read on the following cycle SHALL return the new data.
REQ-027 Memory SHALL be a single-write, single-read array with no combinational path from inputs to outputs.

Reset
REQ-028 While Rst=1: Instruction=32'h0000_0000, Valid=0, AddrFault=0, Busy=1, FSM=FILL, counter=0; Rst SHALL override all other inputs.
REQ-029 Rst asserted mid-fetch or mid-fill SHALL discard the in-flight fetch and restart the full fill; previously loaded program contents are lost.

Verification
REQ-030 Reset pulse, DEPTH=128 -> Busy=1 for exactly 128 edges after release; then fetch each of words 0..127 -> every word 32'h0, Valid=1.
REQ-031 Write 32'h2232_0002 at 0x4, then fetch 0x4 on the next cycle -> one cycle later Instruction=32'h2232_0002, Valid=1, AddrFault=0.
REQ-032 Same-cycle write 32'hDEAD_BEEF and fetch at 0x8 (old 32'h0) -> fetch returns 32'h0; repeat fetch -> 32'hDEAD_BEEF.
REQ-033 Fetch 0x6 and fetch 0x200 -> each returns Instruction=32'h0, Valid=1, AddrFault=1; write to 0x200 -> no word changes.
REQ-034 Deliver a fetch, hold Stall=1 for 3 cycles while Address changes -> Instruction/Valid stay constant; release -> next fetch delivered 1 cycle later.
REQ-035 Assert Rst one cycle after a fetch request -> Valid stays 0, Busy=1, fill restarts from word 0, earlier writes read back as 32'h0.
